eth_mdio_ctrl: RTL and testbench
================================

Name: eth_mdio_ctrl

Overview:
- Hardware MDIO (IEEE 802.3 Clause 22) management-frame sequencer for the RGMII PHY on the Ethernet framing path.
- Replaces register bit-banging of phy_mdc / phy_mdio_o / phy_mdio_oe with a request/response handshake. The register block or a DMA issues one read or write per request; this block serialises the frame and returns read data.
- Sits beside the framing top and drives the PHY management pins directly.

Parameters:
- ClkDiv, 50, clk_i cycles per MDC half-period. MDC = f(clk_i)/(2*ClkDiv), which gives 1.25 MHz at 125 MHz. Must be >= 2; elaboration-time assertion.
- PreambleLen, 32, number of preamble '1' bits (1..32).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_write_i  in  1  1 = write, 0 = read
- req_phy_addr_i  in  5  PHYAD
- req_reg_addr_i  in  5  REGAD
- req_wdata_i  in  16  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  16  read data (0 for writes)
- rsp_error_o  out  1  read turnaround error (no PHY answered)
- busy_o  out  1  high in any state other than IDLE
- phy_mdc_o  out  1  management clock
- phy_mdio_i  in  1  MDIO input
- phy_mdio_o  out  1  MDIO output; forced to 1 when oe = 0
- phy_mdio_oe_o  out  1  MDIO output enable

Behaviour:
- Reset values (the cycle after rst_i is sampled high):
  - state = IDLE, req_ready_o = 1, rsp_valid_o = 0, busy_o = 0
  - phy_mdc_o = 0, phy_mdio_oe_o = 0, phy_mdio_o = 1
  - rsp_rdata_o = 0, rsp_error_o = 0
- Handshake:
  - req_ready_o = (state == IDLE).
  - A request is accepted when valid & ready; all request fields are latched in that cycle.
  - rsp_valid_o is held, with stable data, until rsp_ready_i. A new request is accepted only after the response handshake.
- Bit timing:
  - A free-running divider counts 0..ClkDiv-1 while not in IDLE or RESP.
  - Each bit lasts 2*ClkDiv cycles: MDC is low for the first ClkDiv cycles, high for the second.
  - phy_mdio_o and phy_mdio_oe_o change only on the first cycle of a bit (the MDC falling edge).
  - phy_mdio_i is sampled on the clk_i cycle in which MDC goes 0->1.
- Frame sequence, MSB first, one bit per bit period:
  - PRE: PreambleLen ones.
  - FRAME: ST = 01, then OP (01 write, 10 read), then PHYAD[4:0], then REGAD[4:0].
  - TA:
    - Write: drive 1 then 0.
    - Read: oe = 0 for both bits; the second TA bit is sampled and, if it is 1, rsp_error_o is set.
  - DATA (16 bits):
    - Write: drive wdata[15:0].
    - Read: oe = 0; shift phy_mdio_i into rdata.
  - TAIL: one bit period with oe = 0 and MDC toggling, giving idle spacing.
- States and transitions:
  - IDLE -> PRE on accept.
  - PRE -> FRAME after PreambleLen bits.
  - FRAME -> TA after 14 bits.
  - TA -> DATA after 2 bits.
  - DATA -> TAIL after 16 bits.
  - TAIL -> RESP after 1 bit.
  - RESP -> IDLE on rsp_ready_i.
  - A single 6-bit bit counter is reloaded on each state entry.
- Latency: with PreambleLen = 32, rsp_valid_o rises exactly 1 + 65*2*ClkDiv cycles after the accept cycle.
- In RESP and IDLE: MDC = 0 and oe = 0.
- rsp_error_o is always 0 for writes. For reads, rdata is captured even when error = 1.
- Reset mid-frame: at the next edge go to IDLE with all outputs at their reset values; any pending response is dropped. Nothing is driven on MDIO after the reset edge.
- Simultaneous events: req_valid_i in the RESP cycle where rsp_ready_i = 1 is not accepted; it is accepted one cycle later in IDLE.

Optional Feature:
- Macro: ETH_MDIO_PRE_SUPPRESS_EN.
- When defined:
  - Adds input port req_no_pre_i (1 bit), latched on accept.
  - If it is 1, PRE is skipped (IDLE -> FRAME directly) and latency becomes 1 + (65 - PreambleLen)*2*ClkDiv.
- When undefined: the port is absent and the preamble is always sent.

Test Plan (all with ClkDiv = 2):
- Write PHY 1, reg 0, data 0x1140 -> the mdio_o serial stream is 32 ones, 01, 01, 00001, 00000, 10, 0001000101000000. oe is high for 64 bits. MDC period is 4 cycles. rsp_valid_o rises at cycle 261 with rdata = 0, error = 0.
- Read PHY 3, reg 2, with a PHY model driving TA0 then 0x0141 -> oe drops at the TA start; rsp_rdata_o = 0x0141, rsp_error_o = 0.
- Read with phy_mdio_i tied high (no PHY) -> rsp_rdata_o = 0xFFFF, rsp_error_o = 1.
- Hold rsp_ready_i low for 10 cycles after rsp_valid_o -> response stable, req_ready_o = 0, a second req_valid_i is not accepted. It is accepted one cycle after the response handshake.
- Assert rst_i during DATA bit 5 of a write -> next cycle oe = 0, MDC = 0, req_ready_o = 1, no rsp_valid_o.
- With ETH_MDIO_PRE_SUPPRESS_EN and req_no_pre_i = 1 on a read -> the first driven bits are 01 (ST), with no preamble; rsp_valid_o rises at cycle 133.

Source files
------------

// File: rtl/eth_mdio_ctrl.sv
// ============================================================================
//  Module      : eth_mdio_ctrl
//  Description : IEEE 802.3 Clause 22 MDIO management-frame sequencer.
//                Accepts one read/write request at a time, serialises the
//                frame onto MDC/MDIO and returns read data with a
//                valid/ready response handshake.
//                Optional preamble suppression: ETH_MDIO_PRE_SUPPRESS_EN
//                (adds req_no_pre_i).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_mdio_ctrl #(
   parameter int ClkDiv      = 50,
   parameter int PreambleLen = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [4:0]  req_phy_addr_i,
   input  logic [4:0]  req_reg_addr_i,
   input  logic [15:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_error_o,
   output logic        busy_o,
   output logic        phy_mdc_o,
   input  logic        phy_mdio_i,
   output logic        phy_mdio_o,
   output logic        phy_mdio_oe_o
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
   ,
   input  logic        req_no_pre_i
`endif
);

   localparam int          DIV_W      = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(ClkDiv - 1);
   localparam logic [5:0]  c_pre_load = 6'(PreambleLen - 1);

   // Reject configurations that cannot produce a legal MDC waveform
   generate
      if (ClkDiv < 2) begin : g_bad_clkdiv
         $error("eth_mdio_ctrl: ClkDiv must be >= 2");
      end
      if ((PreambleLen < 1) || (PreambleLen > 32)) begin : g_bad_prelen
         $error("eth_mdio_ctrl: PreambleLen must be in 1..32");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_FRAME = 3'd2,
      S_TA    = 3'd3,
      S_DATA  = 3'd4,
      S_TAIL  = 3'd5,
      S_RESP  = 3'd6
   } state_t;

   state_t           r_state, w_state_n;
   logic [5:0]       r_cnt, w_cnt_n;        // bits remaining in state minus one
   logic [DIV_W-1:0] r_div, w_div_n;        // position inside an MDC half-period
   logic             r_phase, w_phase_n;    // 0 = MDC low half, 1 = MDC high half
   logic             r_mdc, w_mdc_n;
   logic             r_mdo, w_mdo_n;
   logic             r_oe, w_oe_n;
   logic [31:0]      r_sh, w_sh_n;          // ST/OP/PHYAD/REGAD/TA/DATA, MSB first
   logic             r_write, w_write_n;
   logic [15:0]      r_rdata, w_rdata_n;
   logic             r_err, w_err_n;
   logic             w_bit_start;
   logic             w_div_last;
   logic             w_no_pre;

`ifdef ETH_MDIO_PRE_SUPPRESS_EN
   assign w_no_pre = req_no_pre_i;
`else
   assign w_no_pre = 1'b0;
`endif

   assign w_div_last = (r_div == c_div_last);

   // Next-state, bit timing and pin values for the next bit period
   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_div_n     = r_div;
      w_phase_n   = r_phase;
      w_mdc_n     = r_mdc;
      w_mdo_n     = r_mdo;
      w_oe_n      = r_oe;
      w_sh_n      = r_sh;
      w_write_n   = r_write;
      w_rdata_n   = r_rdata;
      w_err_n     = r_err;
      w_bit_start = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_mdc_n = 1'b0;
            w_oe_n  = 1'b0;
            w_mdo_n = 1'b1;
            if (req_valid_i) begin
               // Request fields are captured here; the frame is built once
               w_write_n   = req_write_i;
               w_sh_n      = {2'b01,
                              (req_write_i ? 2'b01 : 2'b10),
                              req_phy_addr_i,
                              req_reg_addr_i,
                              2'b10,
                              (req_write_i ? req_wdata_i : 16'hFFFF)};
               w_rdata_n   = 16'h0000;
               w_err_n     = 1'b0;
               w_div_n     = '0;
               w_phase_n   = 1'b0;
               w_bit_start = 1'b1;
               if (w_no_pre) begin
                  w_state_n = S_FRAME;
                  w_cnt_n   = 6'd13;
               end else begin
                  w_state_n = S_PRE;
                  w_cnt_n   = c_pre_load;
               end
            end
         end

         S_RESP: begin
            w_mdc_n   = 1'b0;
            w_oe_n    = 1'b0;
            w_mdo_n   = 1'b1;
            w_div_n   = '0;
            w_phase_n = 1'b0;
            if (rsp_ready_i) begin
               w_state_n = S_IDLE;
            end
         end

         default: begin
            if (!w_div_last) begin
               w_div_n = r_div + DIV_W'(1);
            end else begin
               w_div_n = '0;
               if (!r_phase) begin
                  // MDC rising edge: the PHY's bit is sampled here
                  w_phase_n = 1'b1;
                  w_mdc_n   = 1'b1;
                  if (!r_write && (r_state == S_TA) && (r_cnt == 6'd0)) begin
                     w_err_n = phy_mdio_i;
                  end
                  if (!r_write && (r_state == S_DATA)) begin
                     w_rdata_n = {r_rdata[14:0], phy_mdio_i};
                  end
               end else begin
                  // MDC falling edge: end of this bit, start of the next
                  w_phase_n = 1'b0;
                  w_mdc_n   = 1'b0;
                  if (r_cnt != 6'd0) begin
                     w_cnt_n     = r_cnt - 6'd1;
                     w_bit_start = 1'b1;
                  end else begin
                     w_bit_start = 1'b1;
                     case (r_state)
                        S_PRE: begin
                           w_state_n = S_FRAME;
                           w_cnt_n   = 6'd13;
                        end
                        S_FRAME: begin
                           w_state_n = S_TA;
                           w_cnt_n   = 6'd1;
                        end
                        S_TA: begin
                           w_state_n = S_DATA;
                           w_cnt_n   = 6'd15;
                        end
                        S_DATA: begin
                           w_state_n = S_TAIL;
                           w_cnt_n   = 6'd0;
                        end
                        default: begin
                           w_state_n   = S_RESP;
                           w_cnt_n     = 6'd0;
                           w_bit_start = 1'b0;
                           w_oe_n      = 1'b0;
                           w_mdo_n     = 1'b1;
                        end
                     endcase
                  end
               end
            end
         end
      endcase

      // Pin values for a new bit depend only on the state it belongs to
      if (w_bit_start) begin
         case (w_state_n)
            S_PRE: begin
               w_mdo_n = 1'b1;
               w_oe_n  = 1'b1;
            end
            S_FRAME: begin
               w_mdo_n = w_sh_n[31];
               w_oe_n  = 1'b1;
               w_sh_n  = {w_sh_n[30:0], 1'b1};
            end
            S_TA, S_DATA: begin
               if (w_write_n) begin
                  w_mdo_n = w_sh_n[31];
                  w_oe_n  = 1'b1;
               end else begin
                  w_mdo_n = 1'b1;
                  w_oe_n  = 1'b0;
               end
               w_sh_n = {w_sh_n[30:0], 1'b1};
            end
            default: begin
               w_mdo_n = 1'b1;
               w_oe_n  = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_div   <= '0;
         r_phase <= 1'b0;
         r_mdc   <= 1'b0;
         r_mdo   <= 1'b1;
         r_oe    <= 1'b0;
         r_sh    <= 32'h0;
         r_write <= 1'b0;
         r_rdata <= 16'h0000;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_div   <= w_div_n;
         r_phase <= w_phase_n;
         r_mdc   <= w_mdc_n;
         r_mdo   <= w_mdo_n;
         r_oe    <= w_oe_n;
         r_sh    <= w_sh_n;
         r_write <= w_write_n;
         r_rdata <= w_rdata_n;
         r_err   <= w_err_n;
      end
   end

   assign req_ready_o   = (r_state == S_IDLE);
   assign busy_o        = (r_state != S_IDLE);
   assign rsp_valid_o   = (r_state == S_RESP);
   assign rsp_rdata_o   = r_rdata;
   assign rsp_error_o   = r_err;
   assign phy_mdc_o     = r_mdc;
   assign phy_mdio_o    = r_mdo;
   assign phy_mdio_oe_o = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_eth_mdio_ctrl.sv
// ============================================================================
//  Module      : tb_eth_mdio_ctrl
//  Description : Self-checking bench for eth_mdio_ctrl (ClkDiv = 2).
//                Expected pin streams, latency and read results come from a
//                bit-list model of the Clause 22 frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_mdio_ctrl;

   localparam int CD  = 2;
   localparam int PRE = 32;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_write_i = 1'b0;
   logic [4:0]  req_phy_addr_i = '0;
   logic [4:0]  req_reg_addr_i = '0;
   logic [15:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [15:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic        busy_o;
   logic        phy_mdc_o;
   logic        phy_mdio_i = 1'b1;
   logic        phy_mdio_o;
   logic        phy_mdio_oe_o;
   logic        req_no_pre_i = 1'b0;

   int checks = 0;
   int errors = 0;

   eth_mdio_ctrl #(.ClkDiv(CD), .PreambleLen(PRE)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_write_i    (req_write_i),
      .req_phy_addr_i (req_phy_addr_i),
      .req_reg_addr_i (req_reg_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_error_o    (rsp_error_o),
      .busy_o         (busy_o),
      .phy_mdc_o      (phy_mdc_o),
      .phy_mdio_i     (phy_mdio_i),
      .phy_mdio_o     (phy_mdio_o),
      .phy_mdio_oe_o  (phy_mdio_oe_o)
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
      ,
      .req_no_pre_i   (req_no_pre_i)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request and follow it to the response. Called just after a
   // negedge with the DUT idle. abort_at > 0 asserts reset at that cycle.
   task automatic run_frame(input string tag, input bit wr, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd, input bit nopre,
                            input bit tied, input logic [15:0] pdata, input bit ta_val,
                            input int abort_at);
      bit          eo[$];
      bit          eoe[$];
      logic [13:0] hdr;
      int          npre, lat, t_rise, mism, b, ph;
      logic        drv;

      // Reference frame: one entry per bit period
      npre = nopre ? 0 : PRE;
      for (int i = 0; i < npre; i++) begin eo.push_back(1'b1); eoe.push_back(1'b1); end
      hdr = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
      for (int i = 13; i >= 0; i--) begin eo.push_back(hdr[i]); eoe.push_back(1'b1); end
      if (wr) begin
         eo.push_back(1'b1); eoe.push_back(1'b1);
         eo.push_back(1'b0); eoe.push_back(1'b1);
      end else begin
         eo.push_back(1'b1); eoe.push_back(1'b0);
         eo.push_back(1'b1); eoe.push_back(1'b0);
      end
      for (int i = 15; i >= 0; i--) begin
         eo.push_back(wr ? wd[i] : 1'b1);
         eoe.push_back(wr);
      end
      eo.push_back(1'b1); eoe.push_back(1'b0);
      lat = 1 + eo.size() * 2 * CD;

      req_write_i    = wr;
      req_phy_addr_i = pa;
      req_reg_addr_i = ra;
      req_wdata_i    = wd;
      req_no_pre_i   = nopre;
      req_valid_i    = 1'b1;
      t_rise = -1;
      mism   = 0;

      for (int t = 1; t <= lat + 20; t++) begin
         @(negedge clk);
         if (t == 1) req_valid_i = 1'b0;
         b  = (t - 1) / (2 * CD);
         ph = (t - 1) % (2 * CD);
         if (t < lat) begin
            if (phy_mdc_o !== (ph >= CD) || phy_mdio_oe_o !== eoe[b] ||
                phy_mdio_o !== eo[b] || rsp_valid_o !== 1'b0 || busy_o !== 1'b1)
               mism++;
            // PHY model: answers on TA bit 1 and the data bits of a read
            drv = 1'b1;
            if (!wr && !tied && b == npre + 15) drv = ta_val;
            if (!wr && !tied && b >= npre + 16 && b < npre + 32) drv = pdata[15 - (b - npre - 16)];
            phy_mdio_i = drv;
         end
         if (abort_at == t) begin
            rst_i = 1'b1;
            @(negedge clk);
            rst_i = 1'b0;
            phy_mdio_i = 1'b1;
            check({tag, ".stream_pre_rst"}, mism, 0);
            check({tag, ".rst_oe"}, phy_mdio_oe_o, 0);
            check({tag, ".rst_mdc"}, phy_mdc_o, 0);
            check({tag, ".rst_mdo"}, phy_mdio_o, 1);
            check({tag, ".rst_ready"}, req_ready_o, 1);
            check({tag, ".rst_rspv"}, rsp_valid_o, 0);
            mism = 0;
            for (int k = 0; k < lat + 20; k++) begin
               @(negedge clk);
               if (rsp_valid_o !== 1'b0 || phy_mdio_oe_o !== 1'b0 || busy_o !== 1'b0) mism++;
            end
            check({tag, ".quiet_after_rst"}, mism, 0);
            return;
         end
         if (rsp_valid_o === 1'b1) begin
            t_rise = t;
            break;
         end
      end
      phy_mdio_i = 1'b1;
      check({tag, ".stream"}, mism, 0);
      check({tag, ".latency"}, t_rise, lat);
      check({tag, ".rdata"}, rsp_rdata_o, wr ? 16'h0000 : (tied ? 16'hFFFF : pdata));
      check({tag, ".error"}, rsp_error_o, wr ? 1'b0 : (tied ? 1'b1 : ta_val));
   endtask

   // Hold the response for d cycles, then complete the handshake.
   task automatic finish_rsp(input string tag, input int d);
      logic [16:0] snap;
      int          mism;
      snap = {rsp_error_o, rsp_rdata_o};
      mism = 0;
      for (int k = 0; k < d; k++) begin
         @(negedge clk);
         if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || {rsp_error_o, rsp_rdata_o} !== snap) mism++;
      end
      check({tag, ".hold"}, mism, 0);
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check({tag, ".rspv_after_hs"}, rsp_valid_o, 0);
      check({tag, ".ready_after_hs"}, req_ready_o, 1);
   endtask

   initial begin
      logic [16:0] snap;
      int          mism;
      bit          wr, tied, tav;

      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      check("reset.ready", req_ready_o, 1);
      check("reset.rspv", rsp_valid_o, 0);
      check("reset.busy", busy_o, 0);
      check("reset.mdc", phy_mdc_o, 0);
      check("reset.oe", phy_mdio_oe_o, 0);
      check("reset.mdo", phy_mdio_o, 1);
      check("reset.rdata", rsp_rdata_o, 0);
      check("reset.error", rsp_error_o, 0);

      // Directed write of 0x1140 to PHY 1 reg 0
      run_frame("wr1140", 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      finish_rsp("wr1140", 2);

      // Directed read answered by a PHY
      run_frame("rd0141", 1'b0, 5'd3, 5'd2, 16'h0, 1'b0, 1'b0, 16'h0141, 1'b0, 0);
      finish_rsp("rd0141", 0);

      // Read with nobody answering
      run_frame("rdnophy", 1'b0, 5'd7, 5'd1, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 0);
      finish_rsp("rdnophy", 1);

      // Held response with a competing request pending
      run_frame("rdhold", 1'b0, 5'd4, 5'd9, 16'h0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 0);
      snap = {rsp_error_o, rsp_rdata_o};
      req_write_i = 1'b1; req_phy_addr_i = 5'd5; req_reg_addr_i = 5'd1;
      req_wdata_i = 16'hA5C3; req_valid_i = 1'b1;
      mism = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || {rsp_error_o, rsp_rdata_o} !== snap) mism++;
      end
      check("hold.stable", mism, 0);
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check("hold.not_accepted_in_hs", req_ready_o, 1);
      check("hold.rspv_dropped", rsp_valid_o, 0);
      run_frame("hold2nd", 1'b1, 5'd5, 5'd1, 16'hA5C3, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      finish_rsp("hold2nd", 0);

      // Reset during DATA bit 5 of a write
      run_frame("wrrst", 1'b1, 5'd2, 5'd4, 16'h5A5A, 1'b0, 1'b0, 16'h0, 1'b0,
                1 + (PRE + 14 + 2 + 5) * 2 * CD + 1);

`ifdef ETH_MDIO_PRE_SUPPRESS_EN
      run_frame("nopre", 1'b0, 5'd3, 5'd2, 16'h0, 1'b1, 1'b0, 16'h0141, 1'b0, 0);
      finish_rsp("nopre", 1);
      req_no_pre_i = 1'b0;
`endif

      // Randomised transactions
      for (int n = 0; n < 6; n++) begin
         wr   = 1'($urandom_range(0, 1));
         tied = ($urandom_range(0, 3) == 0);
         tav  = 1'($urandom_range(0, 1));
         run_frame("rand", wr, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0,
                   tied, 16'($urandom), tav, 0);
         finish_rsp("rand", $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
